change_dispenser: RTL and testbench

//  Downstream end of the vending FSM's d/r outputs. On a dispense event it latches the

---
 rtl/vending_pkg.sv | 17 +
 rtl/change_dispenser_if.sv | 33 +++
 rtl/eject_timer.sv | 28 ++
 rtl/change_dispenser.sv | 144 ++++++++++++++
 tb/tb_change_dispenser.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: coin values and the change-dispenser state encoding.
package vending_pkg;

  localparam int COIN_ONE  = 1;
  localparam int COIN_TWO  = 2;
  localparam int COIN_FIVE = 5;

  typedef enum logic [2:0] {
    CHG_IDLE,
    CHG_SELECT,
    CHG_EJECT1,
    CHG_EJECT2,
    CHG_DONE,
    CHG_FAULT
  } chg_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Request / hopper / status bundle between vending_fsm, the coin hopper and change_dispenser.
interface change_dispenser_if #(
  parameter int CHANGE_W = 3,
  parameter int INV_W    = 6
);

  logic                d;
  logic [CHANGE_W-1:0] r;
  logic                coin_out;
  logic                refill_one;
  logic                refill_two;
  logic                clear_fault;
  logic                eject_one;
  logic                eject_two;
  logic                busy;
  logic                done;
  logic                drop;
  logic                fault;
  logic [CHANGE_W-1:0] owed;
  logic [INV_W-1:0]    ones_left;
  logic [INV_W-1:0]    twos_left;

  modport master (
    output d, r, coin_out, refill_one, refill_two, clear_fault,
    input  eject_one, eject_two, busy, done, drop, fault, owed, ones_left, twos_left
  );

  modport slave (
    input  d, r, coin_out, refill_one, refill_two, clear_fault,
    output eject_one, eject_two, busy, done, drop, fault, owed, ones_left, twos_left
  );

endinterface

// File: rtl/eject_timer.sv
// Per-coin wait counter: cleared between ejects, flags when the last allowed cycle is reached.
module eject_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign timeout = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Pays out latched change coin-by-coin (2-cent first, 1-cent as fallback) and tracks inventory.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CHANGE_W  = 3,
  parameter int INV_W     = 6,
  parameter int INIT_ONES = 20,
  parameter int INIT_TWOS = 20,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  localparam logic [INV_W-1:0] INV_MAX = '1;

  chg_state_t          state_reg, state_next;
  logic [CHANGE_W-1:0] owed_reg, owed_next;
  logic                eject_one_reg, eject_two_reg;
  logic                done_reg, drop_reg, fault_reg, busy_reg;
  logic                in_eject, timeout;
  logic [1:0]          refill, take;
  logic [INV_W-1:0]    inv_left [2];

  assign in_eject = (state_reg == CHG_EJECT1) || (state_reg == CHG_EJECT2);
  assign take     = {(state_reg == CHG_EJECT2) && bus.coin_out,
                     (state_reg == CHG_EJECT1) && bus.coin_out};
  assign refill   = {bus.refill_two, bus.refill_one};

  eject_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_eject || bus.coin_out || timeout),
    .en      (in_eject),
    .timeout (timeout)
  );

  // Index 0 holds 1-cent coins, index 1 holds 2-cent coins.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inv
      localparam logic [INV_W-1:0] INIT = (gi == 0) ? INV_W'(INIT_ONES) : INV_W'(INIT_TWOS);
      logic [INV_W-1:0] count_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= INIT;
        end else if (refill[gi] && !take[gi]) begin
          if (count_reg != INV_MAX) begin
            count_reg <= count_reg + 1'b1;
          end
        end else if (take[gi] && !refill[gi]) begin
          count_reg <= count_reg - 1'b1;
        end
      end

      assign inv_left[gi] = count_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    owed_next  = owed_reg;
    case (state_reg)
      CHG_IDLE: begin
        if (bus.d && (bus.r != '0)) begin
          owed_next  = bus.r;
          state_next = CHG_SELECT;
        end
      end
      CHG_SELECT: begin
        if ((owed_reg >= CHANGE_W'(COIN_TWO)) && (inv_left[1] != '0)) begin
          state_next = CHG_EJECT2;
        end else if ((owed_reg != '0) && (inv_left[0] != '0)) begin
          state_next = CHG_EJECT1;
        end else begin
          state_next = CHG_FAULT;
        end
      end
      CHG_EJECT1: begin
        if (bus.coin_out) begin
          owed_next  = owed_reg - CHANGE_W'(COIN_ONE);
          state_next = (owed_next == '0) ? CHG_DONE : CHG_SELECT;
        end else if (timeout) begin
          state_next = CHG_FAULT;
        end
      end
      CHG_EJECT2: begin
        if (bus.coin_out) begin
          owed_next  = owed_reg - CHANGE_W'(COIN_TWO);
          state_next = (owed_next == '0) ? CHG_DONE : CHG_SELECT;
        end else if (timeout) begin
          state_next = CHG_FAULT;
        end
      end
      CHG_DONE: begin
        state_next = CHG_IDLE;
      end
      CHG_FAULT: begin
        if (bus.clear_fault) begin
          owed_next  = '0;
          state_next = CHG_IDLE;
        end
      end
      default: begin
        state_next = CHG_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CHG_IDLE;
      owed_reg      <= '0;
      eject_one_reg <= 1'b0;
      eject_two_reg <= 1'b0;
      done_reg      <= 1'b0;
      drop_reg      <= 1'b0;
      fault_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owed_reg      <= owed_next;
      eject_one_reg <= (state_next == CHG_EJECT1);
      eject_two_reg <= (state_next == CHG_EJECT2);
      done_reg      <= (state_next == CHG_DONE);
      fault_reg     <= (state_next == CHG_FAULT);
      busy_reg      <= (state_next != CHG_IDLE);
      drop_reg      <= bus.d && (state_reg != CHG_IDLE);
    end
  end

  assign bus.eject_one = eject_one_reg;
  assign bus.eject_two = eject_two_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.drop      = drop_reg;
  assign bus.fault     = fault_reg;
  assign bus.owed      = owed_reg;
  assign bus.ones_left = inv_left[0];
  assign bus.twos_left = inv_left[1];

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table, corner sequences, random traffic vs a coin model.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset = 1'b1;

  change_dispenser_if #(.CHANGE_W(3), .INV_W(6)) bus ();

  change_dispenser #(
    .CHANGE_W(3), .INV_W(6), .INIT_ONES(20), .INIT_TWOS(20), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_ones, m_twos;

  typedef struct {
    int r;
    int dly;
    int n;
    int seq;
    int ones;
    int twos;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Coin-level reference: greedy payout from the current model inventory.
  task automatic model_dispense(input int rr, output int n, output int seq, output bit f, output int rem);
    rem = rr; n = 0; seq = 0; f = 1'b0;
    while (rem > 0 && !f) begin
      if (rem >= 2 && m_twos > 0) begin
        seq |= (1 << n); m_twos--; rem -= 2; n++;
      end else if (m_ones > 0) begin
        m_ones--; rem -= 1; n++;
      end else begin
        f = 1'b1;
      end
    end
  endtask

  task automatic refill(input int n1, input int n2);
    int mx;
    mx = (n1 > n2) ? n1 : n2;
    for (int i = 0; i < mx; i++) begin
      @(negedge clk);
      bus.refill_one = (i < n1);
      bus.refill_two = (i < n2);
      if (i < n1 && m_ones < 63) m_ones++;
      if (i < n2 && m_twos < 63) m_twos++;
    end
    @(negedge clk);
    bus.refill_one = 1'b0;
    bus.refill_two = 1'b0;
  endtask

  // Issue one request and act as the coin hopper, answering each eject after dly cycles.
  task automatic run_dispense(input int rr, input int dly, output int n, output int seq,
                              output bit got_done, output bit got_fault, output int ej_len);
    int cnt;
    n = 0; seq = 0; got_done = 1'b0; got_fault = 1'b0; ej_len = 0; cnt = 0;
    @(negedge clk);
    bus.d = 1'b1;
    bus.r = 3'(rr);
    for (int cyc = 0; cyc < 200 && !got_done && !got_fault; cyc++) begin
      @(negedge clk);
      bus.d = 1'b0;
      bus.coin_out = 1'b0;
      if (bus.eject_one || bus.eject_two) begin
        if (cnt == 0) begin
          if (bus.eject_two) seq |= (1 << n);
          n++;
        end
        cnt++;
        if (cnt > ej_len) ej_len = cnt;
        if (cnt == dly + 1) bus.coin_out = 1'b1;
      end else begin
        cnt = 0;
      end
      if (bus.done) got_done = 1'b1;
      if (bus.fault) got_fault = 1'b1;
    end
    if (!got_done && !got_fault) check("dispense_budget_expired", 0, 1);
    if (got_done) begin
      @(negedge clk);
      check("done_single_pulse", {bus.done, bus.busy}, 0);
    end
  endtask

  task automatic do_txn(input string nm, input int rr, input int dly, input int en, input int eseq,
                        input bit efault, input int eowed, input int eones, input int etwos,
                        output int ej_len);
    int n, seq;
    bit gd, gf;
    run_dispense(rr, dly, n, seq, gd, gf, ej_len);
    check({nm, "_coins"}, n, en);
    check({nm, "_seq"}, seq, eseq);
    check({nm, "_done"}, gd, !efault);
    check({nm, "_fault"}, gf, efault);
    check({nm, "_owed"}, bus.owed, eowed);
    check({nm, "_ones"}, bus.ones_left, eones);
    check({nm, "_twos"}, bus.twos_left, etwos);
  endtask

  task automatic clear_fault_chk(input string nm);
    @(negedge clk);
    bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.clear_fault = 1'b0;
    check({nm, "_clr_fault"}, bus.fault, 0);
    check({nm, "_clr_busy"}, bus.busy, 0);
    check({nm, "_clr_owed"}, bus.owed, 0);
  endtask

  task automatic model_txn(input string nm, input int rr, input int dly);
    int n, seq, rem, ej;
    bit f;
    model_dispense(rr, n, seq, f, rem);
    do_txn(nm, rr, dly, n, seq, f, rem, m_ones, m_twos, ej);
    if (f) clear_fault_chk(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seq, rem, ej, ones_before;
    bit f, found;

    tbl[0] = '{3, 3, 2, 1, 19, 19};
    tbl[1] = '{1, 0, 1, 0, 18, 19};
    tbl[2] = '{2, 5, 1, 1, 18, 18};
    tbl[3] = '{7, 1, 4, 7, 17, 15};
    tbl[4] = '{4, 2, 2, 3, 17, 13};
    tbl[5] = '{5, 7, 3, 3, 16, 11};

    bus.d = 1'b0; bus.r = '0; bus.coin_out = 1'b0;
    bus.refill_one = 1'b0; bus.refill_two = 1'b0; bus.clear_fault = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_ones = 20; m_twos = 20;
    repeat (5) @(negedge clk);
    check("rst_ejects", {bus.eject_one, bus.eject_two}, 0);
    check("rst_flags", {bus.busy, bus.done, bus.drop, bus.fault}, 0);
    check("rst_owed", bus.owed, 0);
    check("rst_ones", bus.ones_left, 20);
    check("rst_twos", bus.twos_left, 20);

    for (int i = 0; i < 6; i++) begin
      model_dispense(tbl[i].r, n, seq, f, rem);
      do_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].dly, tbl[i].n, tbl[i].seq,
             1'b0, 0, tbl[i].ones, tbl[i].twos, ej);
    end

    while (m_twos > 0) model_txn("drain_two", 2, 1);
    model_dispense(4, n, seq, f, rem);
    do_txn("no_twos", 4, 2, 4, 0, 1'b0, 0, 12, 0, ej);

    while (m_ones > 0) model_txn("drain_one", 4, 0);
    model_dispense(1, n, seq, f, rem);
    do_txn("empty", 1, 0, 0, 0, 1'b1, 1, 0, 0, ej);
    clear_fault_chk("empty");

    refill(5, 3);
    do_txn("timeout", 2, 99, 1, 1, 1'b1, 2, 5, 3, ej);
    check("timeout_len", ej, 15);
    clear_fault_chk("timeout");

    // A second request while ejecting is dropped and leaves the payout alone.
    @(negedge clk);
    bus.d = 1'b1; bus.r = 3'd2;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      bus.d = 1'b0;
      if (bus.eject_two) found = 1'b1;
    end
    check("drop_reach_eject2", found, 1);
    bus.d = 1'b1; bus.r = 3'd5;
    @(negedge clk);
    bus.d = 1'b0;
    check("drop_pulse", bus.drop, 1);
    check("drop_owed", bus.owed, 2);
    check("drop_still_eject", bus.eject_two, 1);
    bus.coin_out = 1'b1;
    @(negedge clk);
    bus.coin_out = 1'b0;
    m_twos--;
    check("drop_done", bus.done, 1);
    check("drop_one_cycle", bus.drop, 0);
    check("drop_twos", bus.twos_left, m_twos);
    @(negedge clk);

    // Refill and consume of 1-cent coins on the same edge cancel out.
    ones_before = m_ones;
    @(negedge clk);
    bus.d = 1'b1; bus.r = 3'd1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      bus.d = 1'b0;
      if (bus.eject_one) found = 1'b1;
    end
    check("refill_eject_reach", found, 1);
    bus.coin_out = 1'b1; bus.refill_one = 1'b1;
    @(negedge clk);
    bus.coin_out = 1'b0; bus.refill_one = 1'b0;
    check("refill_eject_done", bus.done, 1);
    check("refill_eject_ones", bus.ones_left, ones_before);
    @(negedge clk);

    refill(0, 66);
    check("sat_twos", bus.twos_left, 63);
    check("sat_model", bus.twos_left, m_twos);

    for (int t = 0; t < 40; t++) begin
      int rr, dly;
      refill($urandom_range(0, 2), $urandom_range(0, 2));
      rr  = $urandom_range(0, 7);
      dly = $urandom_range(0, 10);
      if (rr == 0) begin
        @(negedge clk);
        bus.d = 1'b1; bus.r = '0;
        @(negedge clk);
        bus.d = 1'b0;
        check("r0_not_busy", bus.busy, 0);
        @(negedge clk);
        check("r0_no_done", bus.done, 0);
      end else begin
        model_txn($sformatf("rand%0d", t), rr, dly);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
